cam_stream_mux: RTL

CAM_STREAM_MUX -- requirements
Module: cam_stream_mux

---
 rtl/cam_mux_pkg.sv | 26 ++
 rtl/edge_rise.sv | 29 ++
 rtl/cam_stream_mux.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cam_mux_pkg.sv
// Shared types and sizing helpers for the camera stream multiplexer.
//   state_e   : switch FSM states (IDLE locked to a channel, PEND waiting for target frame start)
//   mode_e    : channel selection policy (MANUAL follows sel, AUTO round-robins)
//   ch_width  : bits needed for a channel index
//   cnt_width : bits needed to hold a count up to and including max_val
package cam_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_e;

  function automatic int unsigned ch_width(input int unsigned n_ch);
    return (n_ch > 1) ? int'($clog2(n_ch)) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? int'($clog2(max_val + 1)) : 1;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// One-bit registered rising-edge detector.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   i_d    : level input
//   o_rise : high in the cycle where i_d is 1 and its registered previous value is 0
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;
  // Masks the first cycle after reset so a level already high at release is not an edge.
  logic r_armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_prev  <= i_d;
      r_armed <= 1'b1;
    end
  end

  assign o_rise = i_d & ~r_prev & r_armed;

endmodule

// File: rtl/cam_stream_mux.sv
// Frame-aligned multiplexer for N_CH camera pixel streams.
// Channel changes (manual via sel, or automatic round-robin every CYCLE_FRAMES frames) only take
// effect on the target channel's vsync rising edge; a pending switch that sees no target frame
// start within TO_CYC cycles is dropped and flags o_err.
//   clk, rst            : clock, asynchronous active-high reset
//   i_vsync/i_href/i_de : per-channel controls, i_data : per-channel pixels (channel k at k*DW)
//   sel, mode           : requested channel, 0 = manual / 1 = auto-cycle
//   o_vsync/o_href/o_de/o_data : selected stream, one cycle of latency
//   o_ch, o_pend, o_err : active channel, switch pending, sticky switch timeout
//   frame_tick          : toggles every TICK frames of the active channel
module cam_stream_mux
  import cam_mux_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned DW           = 16,
  parameter int unsigned CYCLE_FRAMES = 30,
  parameter int unsigned TICK         = 30,
  parameter int unsigned TO_CYC       = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           i_vsync,
  input  logic [N_CH-1:0]           i_href,
  input  logic [N_CH-1:0]           i_de,
  input  logic [N_CH*DW-1:0]        i_data,
  input  logic [ch_width(N_CH)-1:0] sel,
  input  logic                      mode,
  output logic                      o_vsync,
  output logic                      o_href,
  output logic                      o_de,
  output logic [DW-1:0]             o_data,
  output logic [ch_width(N_CH)-1:0] o_ch,
  output logic                      o_pend,
  output logic                      o_err,
  output logic                      frame_tick
);

  localparam int unsigned CW  = ch_width(N_CH);
  localparam int unsigned FCW = cnt_width(CYCLE_FRAMES);
  localparam int unsigned TKW = cnt_width(TICK);
  localparam int unsigned TOW = cnt_width(TO_CYC);

  localparam logic [CW:0]    NCH_V   = (CW + 1)'(N_CH);
  localparam logic [CW-1:0]  LAST_CH = CW'(N_CH - 1);
  localparam logic [FCW-1:0] FC_END  = FCW'(CYCLE_FRAMES);
  localparam logic [TKW-1:0] TK_LAST = TKW'(TICK - 1);
  localparam logic [TOW-1:0] TO_END  = TOW'(TO_CYC);

  logic [N_CH-1:0] w_rise;
  mode_e           w_mode;
  logic            w_sel_ok;
  logic            w_cur_start;
  logic            w_switch;
  logic [CW-1:0]   w_mux_ch;
  logic [CW-1:0]   w_next_ch;
  logic [FCW-1:0]  w_fcnt_inc;
  logic [TOW-1:0]  w_to_inc;

  state_e          r_state;
  mode_e           r_pend_mode;
  logic [CW-1:0]   r_ch;
  logic [CW-1:0]   r_tgt;
  logic [FCW-1:0]  r_fcnt;
  logic [TKW-1:0]  r_tcnt;
  logic [TOW-1:0]  r_to;
  logic            r_err;
  logic            r_tick;

  for (genvar k = 0; k < N_CH; k++) begin : g_edge
    edge_rise u_edge (
      .clk    (clk),
      .rst    (rst),
      .i_d    (i_vsync[k]),
      .o_rise (w_rise[k])
    );
  end

  assign w_mode      = mode_e'(mode);
  assign w_sel_ok    = {1'b0, sel} < NCH_V;
  assign w_cur_start = w_rise[r_ch];
  assign w_switch    = (r_state == PEND) && w_rise[r_tgt];
  // On the switch cycle the target is sampled so its vsync edge is the first output sample.
  assign w_mux_ch    = w_switch ? r_tgt : r_ch;
  assign w_next_ch   = (r_ch == LAST_CH) ? '0 : r_ch + CW'(1);
  assign w_fcnt_inc  = r_fcnt + FCW'(1);
  assign w_to_inc    = r_to + TOW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pend_mode <= MANUAL;
      r_ch        <= '0;
      r_tgt       <= '0;
      r_fcnt      <= '0;
      r_tcnt      <= '0;
      r_to        <= '0;
      r_err       <= 1'b0;
      r_tick      <= 1'b0;
      o_vsync     <= 1'b0;
      o_href      <= 1'b0;
      o_de        <= 1'b0;
      o_data      <= '0;
    end else begin
      o_vsync <= i_vsync[w_mux_ch];
      o_href  <= i_href[w_mux_ch];
      o_de    <= i_de[w_mux_ch];
      o_data  <= i_data[w_mux_ch*DW +: DW];

      if (w_switch) begin
        // A coincident old-channel frame start is deliberately dropped here.
        r_ch    <= r_tgt;
        r_state <= IDLE;
        r_err   <= 1'b0;
        r_fcnt  <= '0;
        r_tcnt  <= '0;
        r_to    <= '0;
      end else begin
        if (w_cur_start) begin
          if (r_tcnt == TK_LAST) begin
            r_tcnt <= '0;
            r_tick <= ~r_tick;
          end else begin
            r_tcnt <= r_tcnt + TKW'(1);
          end
        end

        unique case (r_state)
          IDLE: begin
            if (w_mode == AUTO) begin
              if (w_cur_start) begin
                if (w_fcnt_inc == FC_END) begin
                  r_fcnt      <= '0;
                  r_tgt       <= w_next_ch;
                  r_to        <= '0;
                  r_pend_mode <= AUTO;
                  r_state     <= PEND;
                end else begin
                  r_fcnt <= w_fcnt_inc;
                end
              end
            end else if (w_sel_ok && (sel != r_ch)) begin
              r_tgt       <= sel;
              r_to        <= '0;
              r_pend_mode <= MANUAL;
              r_state     <= PEND;
            end
          end
          PEND: begin
            if (w_mode != r_pend_mode) begin
              r_to    <= '0;
              r_state <= IDLE;
            end else if ((w_mode == MANUAL) && (sel == r_ch)) begin
              // Request withdrawn: stay on the current channel.
              r_to    <= '0;
              r_state <= IDLE;
            end else begin
              if ((w_mode == MANUAL) && w_sel_ok) begin
                r_tgt <= sel;
              end
              if (w_to_inc == TO_END) begin
                r_to    <= '0;
                r_err   <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_to <= w_to_inc;
              end
            end
          end
        endcase
      end
    end
  end

  assign o_ch       = r_ch;
  assign o_pend     = (r_state == PEND);
  assign o_err      = r_err;
  assign frame_tick = r_tick;

endmodule
